// File: rtl/icache_direct_if.sv
// Bundle of signals between the fetch stage, the instruction cache and the memory controller.
// The slave modport is the cache's view; the master modport is the view of the environment around it.
interface icache_direct_if #(
    parameter int WORD_W = 32
);
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic [WORD_W-1:0] iload;
    logic              iwait;
    logic              flush;
    logic [WORD_W-1:0] hit_count;
    logic [WORD_W-1:0] miss_count;

    modport slave (
        input  imemREN, imemaddr, iload, iwait, flush,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, iload, iwait, flush,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache with a zero-latency hit path
// and a blocking miss that fills from memory through an iREN/iwait handshake.
module icache_direct #(
    parameter int SETS   = 16,
    parameter int WORD_W = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    icache_direct_if.slave     bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t              state_reg, state_next;
    logic [WORD_W-3:0]   miss_addr_reg, miss_addr_next;
    logic [SETS-1:0]     valid_reg;
    logic [WORD_W-1:0]   hit_count_reg, hit_count_next;
    logic [WORD_W-1:0]   miss_count_reg, miss_count_next;

    // Tag and data are read asynchronously so a hit returns in the request cycle.
    logic [TAG_W-1:0]    tag_mem  [SETS];
    logic [WORD_W-1:0]   data_mem [SETS];

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    miss_tag;
    logic [IDX_W-1:0]    miss_idx;

    logic                hit;
    logic                fill_en;
    logic [WORD_W-1:0]   hit_data;

    assign req_tag  = bus.imemaddr[WORD_W-1:IDX_W+2];
    assign req_idx  = bus.imemaddr[IDX_W+1:2];
    assign miss_tag = miss_addr_reg[WORD_W-3:IDX_W];
    assign miss_idx = miss_addr_reg[IDX_W-1:0];

    always_comb begin
        state_next      = state_reg;
        miss_addr_next  = miss_addr_reg;
        hit             = 1'b0;
        fill_en         = 1'b0;
        hit_data        = '0;
        hit_count_next  = hit_count_reg;
        miss_count_next = miss_count_reg;
        case (state_reg)
            IDLE: begin
                if (bus.imemREN) begin
                    // A flush in the same cycle suppresses the hit and turns it into a miss.
                    if (valid_reg[req_idx] && (tag_mem[req_idx] == req_tag) && !bus.flush) begin
                        hit      = 1'b1;
                        hit_data = data_mem[req_idx];
                        if (hit_count_reg != '1)
                            hit_count_next = hit_count_reg + WORD_W'(1);
                    end else begin
                        miss_addr_next = {req_tag, req_idx};
                        state_next     = MISS;
                        if (miss_count_reg != '1)
                            miss_count_next = miss_count_reg + WORD_W'(1);
                    end
                end
            end
            MISS: begin
                if (!bus.iwait) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_reg      <= IDLE;
            miss_addr_reg  <= '0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            miss_addr_reg  <= miss_addr_next;
            hit_count_reg  <= hit_count_next;
            miss_count_reg <= miss_count_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_en && !nRST) begin
            data_mem[miss_idx] <= bus.iload;
            tag_mem[miss_idx]  <= miss_tag;
        end
    end

    // Flush beats the fill's set-valid, so a frame filled on a flush edge stays invalid.
    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge CLK) begin
                if (nRST || bus.flush)
                    valid_reg[gi] <= 1'b0;
                else if (fill_en && (miss_idx == IDX_W'(gi)))
                    valid_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    assign bus.ihit       = hit && !nRST;
    assign bus.imemload   = (hit && !nRST) ? hit_data : '0;
    assign bus.iREN       = (state_reg == MISS) && !nRST;
    assign bus.iaddr      = ((state_reg == MISS) && !nRST) ? {miss_addr_reg, 2'b00} : '0;
    assign bus.hit_count  = hit_count_reg;
    assign bus.miss_count = miss_count_reg;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: a reference model predicts each cycle's outputs,
// which are queued at drive time and compared against the DUT on the falling edge.
module tb_icache_direct;
    logic clk;
    logic nrst;

    icache_direct_if #(.WORD_W(32)) bus ();

    icache_direct #(.SETS(16), .WORD_W(32)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ihit;
        logic [31:0] load;
        logic        iren;
        logic [31:0] iaddr;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
    endtask

    // Backing memory contents; 0x40 carries the instruction used in the cold-miss scenario.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Reference model: each frame remembers the full word address it holds.
    bit          m_valid [16];
    logic [31:0] m_laddr [16];
    bit          m_miss;
    logic [31:0] m_miss_addr;
    int          m_wait;
    logic [31:0] m_hc, m_mc;
    int          lat;
    bit          chk_en;

    function automatic bit model_hit(input logic ren, input logic [31:0] addr, input logic fl);
        logic [31:0] al;
        al = {addr[31:2], 2'b00};
        return !m_miss && ren && !fl && m_valid[addr[5:2]] && (m_laddr[addr[5:2]] == al);
    endfunction

    task automatic cyc(input logic ren, input logic [31:0] addr, input logic fl, input logic rst);
        exp_t e;
        bit   h;
        bus.imemREN  = ren;
        bus.imemaddr = addr;
        bus.flush    = fl;
        nrst         = rst;
        bus.iwait    = m_miss && (m_wait > 0);
        bus.iload    = (m_miss && m_wait == 0) ? mem_word(m_miss_addr) : 32'hBADC_0FFE;
        h       = model_hit(ren, addr, fl) && !rst;
        e.ihit  = h;
        e.load  = h ? mem_word({addr[31:2], 2'b00}) : 32'h0;
        e.iren  = m_miss && !rst;
        e.iaddr = (m_miss && !rst) ? m_miss_addr : 32'h0;
        e.hc    = m_hc;
        e.mc    = m_mc;
        if (chk_en) exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
            m_miss = 0;
            m_hc   = 0;
            m_mc   = 0;
        end else begin
            if (!m_miss) begin
                if (h) begin
                    if (m_hc != 32'hFFFF_FFFF) m_hc++;
                end else if (ren) begin
                    if (m_mc != 32'hFFFF_FFFF) m_mc++;
                    m_miss_addr = {addr[31:2], 2'b00};
                    m_wait      = lat;
                    m_miss      = 1;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else begin
                m_valid[m_miss_addr[5:2]] = 1;
                m_laddr[m_miss_addr[5:2]] = m_miss_addr;
                m_miss = 0;
            end
            if (fl) for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end
    endtask

    task automatic run(input logic [31:0] addr, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, addr, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ihit",       {31'b0, bus.ihit}, {31'b0, e.ihit});
            check("imemload",   bus.imemload,      e.load);
            check("iREN",       {31'b0, bus.iREN}, {31'b0, e.iren});
            check("iaddr",      bus.iaddr,         e.iaddr);
            check("hit_count",  bus.hit_count,     e.hc);
            check("miss_count", bus.miss_count,    e.mc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_laddr[i] = 32'h0;
        end
        m_miss = 0; m_miss_addr = 0; m_wait = 0; m_hc = 0; m_mc = 0; lat = 0;
        chk_en = 0;
        nrst = 1'b1; bus.imemREN = 1'b0; bus.imemaddr = 0; bus.flush = 1'b0;
        bus.iwait = 1'b0; bus.iload = 0;
        @(posedge clk);
        #1;
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk_en = 1;
        cyc(1'b1, 32'h40, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Cold miss with three wait cycles, then five hits on 0x40 and one on 0x42.
        lat = 3;
        run(32'h40, 6);
        check("cold_miss_count", bus.miss_count, 32'd1);
        run(32'h40, 5);
        run(32'h42, 1);

        // Conflict eviction on index 0.
        lat = 2;
        run(32'h440, 5);
        lat = 1;
        run(32'h40, 4);
        check("evict_miss_count", bus.miss_count, 32'd3);

        // Address changes while the fill for 0x80 is outstanding.
        lat = 3;
        run(32'h80, 1);
        run(32'h84, 10);
        run(32'h80, 1);

        // Flush in a request cycle, then flush on the fill edge.
        lat = 1;
        run(32'h44, 4);
        run(32'h40, 1);
        lat = 2;
        cyc(1'b1, 32'h40, 1'b1, 1'b0);
        run(32'h40, 2);
        cyc(1'b1, 32'h40, 1'b1, 1'b0);
        run(32'h40, 5);
        lat = 0;
        run(32'h44, 3);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset while a fill of 0x100 is waiting.
        lat = 5;
        run(32'h100, 3);
        cyc(1'b1, 32'h100, 1'b0, 1'b1);
        lat = 1;
        run(32'h100, 4);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        run(32'h40, 1);

        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-block instruction cache that sits directly downstream of the pipelined datapath's instruction-fetch port.
- Serves the datapath's fetch requests (imemREN/imemaddr) and returns ihit/imemload, which gate the PC and the IF/ID latch.
- On a miss it fetches the word from the memory controller through a wait-based handshake, fills the frame, and then reports the hit.
- Read-only; instruction writes are not supported.

Parameters:
- SETS, 16, number of frames; power of two; IDX_W = log2(SETS).
- WORD_W, 32, data and address width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset, synchronous, active-high (asserted = 1); name kept from the codebase port set.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  WORD_W  fetch byte address; bits [1:0] ignored.
- ihit  out  1  requested word valid this cycle.
- imemload  out  WORD_W  fetched instruction.
- iREN  out  1  memory read request.
- iaddr  out  WORD_W  memory word address (low 2 bits forced 0).
- iload  in  WORD_W  memory read data.
- iwait  in  1  memory busy; data on iload is valid in the cycle iREN=1 and iwait=0.
- flush  in  1  invalidate all frames.
- hit_count  out  WORD_W  saturating count of hit cycles.
- miss_count  out  WORD_W  saturating count of misses.

Behaviour:
- Address split: tag = imemaddr[WORD_W-1 : IDX_W+2], index = imemaddr[IDX_W+1:2], offset = [1:0] (ignored).
- Storage per frame: valid bit, tag, data word.
- Reset (nRST=1 at edge):
  - all valid bits cleared; FSM goes to IDLE; counters cleared.
  - Outputs in the reset cycle and after: ihit=0, iREN=0, iaddr=0, imemload=0.
  - Reset mid-miss abandons the fill with no frame write; iREN drops the next cycle.
- FSM states: IDLE, MISS.
- IDLE:
  - Hit when imemREN=1, valid[index]=1 and tag matches. Then ihit=1 combinationally in the same cycle and imemload = data[index]; zero-cycle hit latency.
  - Miss when imemREN=1 and there is no hit: latch {tag, index} into miss_addr, increment miss_count, go to MISS. ihit=0 this cycle.
  - imemREN=0: ihit=0, imemload=0, stay in IDLE.
- MISS:
  - iREN=1; iaddr = {miss_addr, 2'b00}; ihit=0.
  - While iwait=1: hold state.
  - When iwait=0: write iload into frame[miss index], set valid, store tag, go to IDLE.
  - The next cycle re-evaluates the request and normally hits; total miss penalty is memory latency + 1 cycle.
- Address changes or imemREN drops during MISS: the fill still completes to the latched miss_addr. The new address is evaluated only on return to IDLE.
- flush=1 at an edge:
  - Clears all valid bits.
  - In MISS, the fill in progress still writes data but its valid bit ends 0. Flush has priority over fill-set-valid in the same edge.
  - In the flush cycle, ihit is forced to 0.
- hit_count increments on each cycle with ihit=1. Both counters saturate at all-ones with no wrap.
- No combinational path from iload to ihit or imemload.
- iREN is registered from state, so glitch-free.
- Simultaneous nRST and flush: reset wins.

Test Plan:
- Cold miss:
  - Stimulus: reset, then imemREN=1, imemaddr=0x00000040; memory returns iload=0x8C220004 after iwait=1 for 3 cycles.
  - Response: iREN=1 with iaddr=0x40 for 4 cycles, ihit=1 with imemload=0x8C220004 on the 6th cycle, miss_count=1.
- Hit path:
  - Stimulus: after the fill above, hold 0x40 for 5 cycles, then 0x42.
  - Response: ihit=1 in every cycle, iREN=0, hit_count increments by 1 per cycle, and 0x42 also hits (offset ignored).
- Conflict eviction:
  - Stimulus: fill 0x40 and then 0x440 (same index 0, SETS=16).
  - Response: 0x440 misses; re-requesting 0x40 misses again and re-fills; miss_count=3.
- Address change mid-miss:
  - Stimulus: miss on 0x80; during iwait=1 switch imemaddr to 0x84.
  - Response: iaddr stays 0x80 until the fill completes, then a second miss on 0x84; both frames valid afterwards.
- Flush:
  - Stimulus: fill 0x40 and 0x44, assert flush for 1 cycle, re-request 0x40.
  - Response: ihit=0 in the flush cycle; 0x40 misses (iREN=1). Flush asserted on the fill edge leaves the frame invalid.
- Reset mid-miss:
  - Stimulus: miss on 0x100 with iwait=1; assert nRST=1 for 1 cycle.
  - Response: iREN=0 the following cycle, no frame written, counters 0, and the next request to 0x100 misses.
